// File: rtl/misr_response_analyzer.sv
// misr_response_analyzer
//   Response side of the per-scan BIST. The scan chain outputs are compacted
//   in a Galois-form MISR. After the programmed number of pattern unloads the
//   final signature is compared with GOLDEN and the result is reported.
//   Protocol errors from the controller are also detected: test_end arriving
//   before the last unload has finished, or in the middle of an unload.
// Ports
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high
//   bist_start : 1-cycle pulse; clears the block and begins a session (from any state)
//   shift_en   : scan_in is valid this cycle and is compacted
//   scan_in    : N_CHAINS scan chain outputs
//   test_end   : controller declares that the session is finished
//   busy       : session in progress (COMPACT or COMPARE)
//   bist_end   : result valid; held until the next bist_start or reset
//   pass_nfail : 1 = signature matched and no protocol error (qualified by bist_end)
//   signature  : current MISR contents
module misr_response_analyzer #(
  parameter int unsigned       MISR_W     = 16,
  parameter int unsigned       N_CHAINS   = 1,
  parameter int unsigned       CHAIN_LEN  = 8,
  parameter int unsigned       N_PATTERNS = 64,
  parameter logic [MISR_W-1:0] POLY       = 16'h1021,
  parameter logic [MISR_W-1:0] GOLDEN     = 16'h0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                bist_start,
  input  logic                shift_en,
  input  logic [N_CHAINS-1:0] scan_in,
  input  logic                test_end,
  output logic                busy,
  output logic                bist_end,
  output logic                pass_nfail,
  output logic [MISR_W-1:0]   signature
);

  localparam int unsigned SCW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned PCW = $clog2(N_PATTERNS + 1);
  localparam logic [SCW-1:0] SHIFT_LAST = SCW'(CHAIN_LEN - 1);
  localparam logic [PCW-1:0] PAT_LAST   = PCW'(N_PATTERNS - 1);

  typedef enum logic [1:0] {IDLE, COMPACT, COMPARE, DONE} state_t;

  state_t            state;
  logic [MISR_W-1:0] misr;
  logic [SCW-1:0]    shift_cnt;
  logic [PCW-1:0]    pat_cnt;
  logic              err;

  logic [MISR_W-1:0] scan_ext;
  logic [MISR_W-1:0] misr_next;
  logic              last_shift;
  logic              final_shift;

  always_comb begin
    // zero-extend through a variable so MISR_W == N_CHAINS needs no zero-width replication
    scan_ext                 = '0;
    scan_ext[N_CHAINS-1:0]   = scan_in;
    misr_next   = {misr[MISR_W-2:0], 1'b0} ^ (misr[MISR_W-1] ? POLY : '0) ^ scan_ext;
    last_shift  = shift_en && (shift_cnt == SHIFT_LAST);
    final_shift = last_shift && (pat_cnt == PAT_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      misr       <= '0;
      shift_cnt  <= '0;
      pat_cnt    <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      bist_end   <= 1'b0;
      pass_nfail <= 1'b0;
    end else if (bist_start) begin
      // start wins over everything, including a same-cycle shift, and aborts a running session
      state      <= COMPACT;
      misr       <= '0;
      shift_cnt  <= '0;
      pat_cnt    <= '0;
      err        <= 1'b0;
      busy       <= 1'b1;
      bist_end   <= 1'b0;
      pass_nfail <= 1'b0;
    end else begin
      case (state)
        COMPACT: begin
          if (shift_en) begin
            misr <= misr_next;
            if (last_shift) begin
              shift_cnt <= '0;
              pat_cnt   <= pat_cnt + 1'b1;
            end else begin
              shift_cnt <= shift_cnt + 1'b1;
            end
          end
          // pat_cnt < N_PATTERNS always holds here, so any test_end that
          // does not coincide with the completing shift is a protocol error
          if (final_shift) begin
            state <= COMPARE;
          end else if (test_end) begin
            err   <= 1'b1;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          bist_end   <= 1'b1;
          pass_nfail <= (misr == GOLDEN) && !err;
          busy       <= 1'b0;
          state      <= DONE;
        end
        default: ;  // IDLE and DONE hold everything until bist_start
      endcase
    end
  end

  assign signature = misr;

endmodule
